// File: rtl/terminal_core.sv
// terminal_core: character-cell terminal store with cursor, scrolling and clear.
// One N x CHAR_W RAM is addressed through a circular top-row pointer, so scrolling
// only has to blank the new bottom row instead of moving the whole screen.
module terminal_core #(
    parameter int COLS      = 40,
    parameter int ROWS      = 24,
    parameter int CHAR_W    = 6,
    parameter int BLINK_DIV = 2**22,
    localparam int N        = COLS * ROWS,
    localparam int AW       = $clog2(N),
    localparam int CW       = $clog2(COLS),
    localparam int RW       = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        rd,
    input  logic              da,
    output logic              rda_n,
    input  logic              clr_btn,
    input  logic [AW-1:0]     vid_addr,
    output logic [CHAR_W-1:0] vid_char,
    output logic              vid_curs,
    output logic [CW-1:0]     cur_col,
    output logic [RW-1:0]     cur_row,
    output logic              busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WRITE  = 2'd1;
    localparam logic [1:0] SCROLL = 2'd2;
    localparam logic [1:0] CLEAR  = 2'd3;

    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [CHAR_W-1:0] BLANK = CHAR_W'(7'h20);

    logic [1:0]        state;
    logic              boot;      // first cycle after reset still owes a clear
    logic              armed;     // da=0 seen in IDLE since the last accept
    logic [6:0]        ch;
    logic [RW-1:0]     top, row;
    logic [CW-1:0]     col, scol;
    logic [AW-1:0]     cptr;
    logic [BW-1:0]     bcnt;
    logic              phase;

    logic [CHAR_W-1:0] mem [N];

    logic              we;
    logic [AW-1:0]     waddr;
    logic [CHAR_W-1:0] wdata;

    logic              go_clear, accept, adv;
    logic              printable, is_cr, at_eol, at_bottom;
    logic [RW-1:0]     top_next;

    logic [AW-1:0]     vq, vc, raddr;
    logic              in_range, curs_hit;

    // logical (row, col) -> physical cell, rotating rows by the top pointer
    function automatic logic [AW-1:0] phys(input logic [RW-1:0] t,
                                           input logic [RW-1:0] r,
                                           input logic [CW-1:0] c);
        logic [RW:0] s;
        s = {1'b0, t} + {1'b0, r};
        if (s >= (RW+1)'(ROWS)) s = s - (RW+1)'(ROWS);
        return AW'(s) * AW'(COLS) + AW'(c);
    endfunction

    // control decode of the latched character and FSM events
    always_comb begin
        printable = ch[6:5] != 2'b00;
        is_cr     = ch == 7'h0D;
        at_eol    = col == CW'(COLS - 1);
        at_bottom = row == RW'(ROWS - 1);
        top_next  = (top == RW'(ROWS - 1)) ? '0 : top + 1'b1;
        go_clear  = (state != CLEAR) && (clr_btn || (state == IDLE && boot));
        accept    = (state == IDLE) && !go_clear && armed && da;
        adv       = (state == WRITE) && !clr_btn && ((printable && at_eol) || is_cr);
        rda_n     = !((state == IDLE) && armed);
        busy      = (state == SCROLL) || (state == CLEAR);
        cur_col   = col;
        cur_row   = row;
    end

    // single RAM write port shared by WRITE, SCROLL and CLEAR
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = BLANK;
        if (!rst) begin
            case (state)
                WRITE: if (!clr_btn && printable) begin
                    we    = 1'b1;
                    waddr = phys(top, row, col);
                    wdata = ch[CHAR_W-1:0];
                end
                SCROLL: if (!clr_btn) begin
                    we    = 1'b1;
                    waddr = phys(top, RW'(ROWS - 1), scol);
                end
                CLEAR: begin
                    we    = 1'b1;
                    waddr = cptr;
                end
                default: ;
            endcase
        end
    end

    // character RAM write
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // scanner address split into logical row/col and rotated through top
    always_comb begin
        vq       = vid_addr / AW'(COLS);
        vc       = vid_addr % AW'(COLS);
        in_range = {1'b0, vid_addr} < (AW+1)'(N);
        raddr    = phys(top, RW'(vq), CW'(vc));
        curs_hit = (vq == AW'(row)) && (vc == AW'(col));
    end

    // registered video read port
    always_ff @(posedge clk) begin
        if (rst) begin
            vid_char <= '0;
            vid_curs <= 1'b0;
        end else if (in_range) begin
            vid_char <= mem[raddr];
            vid_curs <= curs_hit && phase;
        end else begin
            vid_char <= '0;
            vid_curs <= 1'b0;
        end
    end

    // main FSM: handshake, character decode, scroll and clear sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            boot  <= 1'b1;
            armed <= 1'b0;
            ch    <= '0;
            top   <= '0;
            row   <= '0;
            col   <= '0;
            scol  <= '0;
            cptr  <= '0;
        end else if (go_clear) begin
            state <= CLEAR;
            boot  <= 1'b0;
            armed <= 1'b0;
            ch    <= '0;
            top   <= '0;
            row   <= '0;
            col   <= '0;
            cptr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!da) armed <= 1'b1;
                    if (accept) begin
                        ch    <= rd;
                        armed <= 1'b0;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                    if (printable) col <= at_eol ? '0 : col + 1'b1;
                    else if (is_cr) col <= '0;
                    if (adv) begin
                        if (at_bottom) begin
                            top   <= top_next;
                            scol  <= '0;
                            state <= SCROLL;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                SCROLL: begin
                    if (scol == CW'(COLS - 1)) state <= IDLE;
                    else scol <= scol + 1'b1;
                end
                default: begin
                    if (cptr == AW'(N - 1)) state <= IDLE;
                    else cptr <= cptr + 1'b1;
                end
            endcase
        end
    end

    // free-running cursor blink, restarted in the on phase by every accept
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (bcnt == BW'(BLINK_DIV - 1)) begin
            bcnt  <= '0;
            phase <= !phase;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

endmodule

// File: doc/terminal_core.md
TERMINAL_CORE -- requirements
Module: terminal_core

Interface
REQ-001 Parameter COLS, default 40, characters per row (2..128).
REQ-002 Parameter ROWS, default 24, rows per screen (2..64).
REQ-003 Parameter CHAR_W, default 6, stored bits per character (5..7).
REQ-004 Parameter BLINK_DIV, default 2**22, clk cycles per cursor blink half-period (>=2).
REQ-005 Derived: N = COLS*ROWS cells; AW = clog2(N).
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd  in  7  ASCII character from the keyboard/PIA side.
- da  in  1  data available, active-high level.
- rda_n  out  1  ready for data, active-low.
- clr_btn  in  1  clear-screen request, active-high.
- vid_addr  in  AW  scanner cell index, row-major, row 0 = visible top row.
- vid_char  out  CHAR_W  character at vid_addr, registered.
- vid_curs  out  1  high when vid_addr is the cursor cell and blink phase is on; registered, aligned with vid_char.
- cur_col  out  clog2(COLS)  cursor column.
- cur_row  out  clog2(ROWS)  cursor row.
- busy  out  1  high while in CLEAR or SCROLL.

Function
REQ-007 The block SHALL hold one N x CHAR_W character RAM with one write port and one synchronous read port.
REQ-008 The physical address SHALL be ((top + row) mod ROWS)*COLS + col, where top is a circular row pointer in 0..ROWS-1.
REQ-009 The read port SHALL map vid_addr through top, so vid_char and vid_curs follow vid_addr by exactly 1 clk.
REQ-010 vid_addr >= N SHALL return vid_char = 0 and vid_curs = 0.
REQ-011 The FSM SHALL have four states: IDLE, WRITE, SCROLL and CLEAR.
REQ-012 In IDLE, rda_n SHALL be 0 only when da = 0 was sampled in IDLE since the last accept.
- Accept condition: da = 1 while rda_n = 0.
- On accept: rd latched; rda_n = 1 from the next cycle; go to WRITE.
REQ-013 WRITE SHALL take 1 cycle and decode the latched character.
- Printable (rd[6:5] != 00): store rd[CHAR_W-1:0] at the cursor; col += 1.
- When col was COLS-1: col = 0 and perform a row advance.
REQ-014 CR (0x0D) SHALL store nothing, set col = 0 and perform a row advance.
REQ-015 Other control codes (rd[6:5] = 00, not 0x0D) SHALL be consumed with no change to RAM or cursor.
REQ-016 Row advance SHALL behave as follows.
- row < ROWS-1: row += 1; return to IDLE.
- row = ROWS-1: top = (top+1) mod ROWS; enter SCROLL.
REQ-017 SCROLL SHALL write blank (CHAR_W'h20 truncated) to the COLS cells of the new bottom row, one per cycle, in exactly COLS cycles, then go to IDLE; row stays ROWS-1.
REQ-018 CLEAR SHALL perform the following, then go to IDLE.
- Write blank to all N physical cells, one per cycle, in exactly N cycles.
- top, col and row = 0 on entry.
REQ-019 clr_btn = 1 in IDLE or WRITE SHALL enter CLEAR next cycle, discarding any latched character.
REQ-020 clr_btn SHALL win over a simultaneous accept.
REQ-021 clr_btn during SCROLL SHALL abort it and enter CLEAR.
REQ-022 clr_btn during CLEAR SHALL be ignored (no restart).
REQ-023 rda_n SHALL stay 1 throughout WRITE, SCROLL and CLEAR.
REQ-024 busy SHALL be 1 exactly in SCROLL and CLEAR.
REQ-025 A blink counter SHALL toggle the blink phase every BLINK_DIV cycles, free-running.
REQ-026 Any accepted character SHALL reset the blink counter and force the phase on.

Reset
REQ-027 With rst = 1 at a clk edge, the block SHALL set the following.
- rda_n = 1, busy = 0, vid_char = 0, vid_curs = 0.
- cur_col = 0, cur_row = 0, top = 0.
- Blink counter = 0, phase on; latched character discarded.
REQ-028 After rst deasserts, the FSM SHALL enter CLEAR on the first cycle, so busy = 1 for N cycles before the first rda_n = 0.
REQ-029 rst asserted mid-WRITE, SCROLL or CLEAR SHALL abort the operation with no further RAM writes; RAM contents are not otherwise reset.

Verification
REQ-030 Reset release with defaults -> busy = 1 for 960 cycles; then rda_n = 0; all cells read 0x20; cursor at (0,0).
REQ-031 Send 0x41 ('A') then 0x0D -> cell 0 reads 0x01 (6-bit 'A'); cursor at (col 0, row 1); rda_n returns to 0 only after da drops.
REQ-032 Send 40 printable chars from (0,0) -> the 40th lands at col 39; cursor wraps to (0,1) with no scroll.
REQ-033 At row 23 send CR -> busy = 1 for exactly 40 cycles; old row 1 appears at vid_addr 0; bottom row all 0x20; cursor at (0,23).
REQ-034 Assert da and clr_btn on the same edge in IDLE -> no character written; CLEAR runs 960 cycles; cursor at (0,0).
REQ-035 Set BLINK_DIV = 4; point vid_addr at the cursor cell -> vid_curs toggles every 4 cycles and is forced to 1 on the cycle after an accept.
